hash_bus_if: RTL and testbench
==============================

Name: hash_bus_if

Overview:
- Parametrised narrow-bus front end for the hash cores: serially loads one message block from a DW-bit host bus and presents it in parallel to the core with a one-cycle start pulse.
- Captures the core's digest when the core finishes and returns it to the host in DW-bit beats.
- Successor to the fixed 16-bit/256-bit interface. Adds generic widths, optional per-lane byte reversal, a block counter for tweak/position, re-readable digest and a sticky protocol-error flag.

Parameters:
DW, 16, host bus width in bits; divides MSG_W, DIG_W and LANE_W, and is a multiple of 8
MSG_W, 256, message block width in bits
DIG_W, 256, digest width in bits
LANE_W, 64, byte-reversal lane width; divides MSG_W
BSWAP, 1, 1 = reverse byte order within each LANE_W lane of msg; 0 = pass-through
CNT_W, 32, block counter width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
init  input  1  synchronous clear of interface state; forwarded to the core
load  input  1  host strobe: idata carries the next message beat
fetch  input  1  host strobe: request the next digest beat
idata  input  DW  host write data
odata  output  DW  host read data (registered)
ack  output  1  one-cycle acknowledge of an accepted load/fetch beat
err  output  1  sticky protocol error
core_init  output  1  registered copy of init
start  output  1  one-cycle pulse: msg is complete and stable
busy  input  1  core busy
msg  output  MSG_W  assembled block (after optional byte reversal)
digest  input  DIG_W  core result; valid on busy falling edge
blk_cnt  output  CNT_W  blocks started since init

Behaviour:
Reset (rst_n=0, asynchronous):
- All registers 0, state IDLE.
- odata, ack, err, core_init, start, msg and blk_cnt are all 0.
- Reset mid-operation abandons any partial block or pending digest.

Constants:
- NM = MSG_W/DW load beats; ND = DIG_W/DW fetch beats.

init (synchronous, highest priority):
- Clears beat counters, message buffer, dig_valid, err and blk_cnt; state goes to IDLE.
- core_init = init delayed by 1 cycle.
- load and fetch in the same cycle are ignored, with no ack.

States: IDLE, LOAD, WAIT, DONE.

IDLE / DONE, on load:
- Writes idata to beat 0; beat k occupies buffer bits [MSG_W-1-k*DW -: DW].
- Clears dig_valid and fetch counter; state goes to LOAD with lcnt=1.

LOAD, on load:
- Writes beat lcnt and increments lcnt.
- On beat NM-1: the next cycle start=1 for exactly 1 cycle, blk_cnt increments (wraps at 2^CNT_W), state goes to WAIT.
- With NM=1, beat 0 completes the block directly.

WAIT:
- Core contract: busy rises the cycle after start.
- Interface captures digest on busy_q=1 and busy=0, sets dig_valid, state goes to DONE.
- load or fetch in WAIT: rejected, err=1, no ack, buffer unchanged.

msg output:
- Held stable from start until the next accepted load.
- If BSWAP=1, the bytes of each LANE_W lane are reversed, giving little-endian presentation of the host byte stream.

fetch (in DONE with dig_valid=1):
- odata = digest beat fcnt (beat 0 = MSB), registered, valid the cycle after fetch together with ack.
- fcnt increments and wraps to 0 after ND-1, so the digest may be re-read.

fetch with dig_valid=0 (IDLE, or LOAD after the first beat):
- err=1, odata unchanged, no ack.

ack:
- ack=1 the cycle after each accepted load or fetch; otherwise 0.

Simultaneous load and fetch:
- load takes priority; fetch is dropped silently (no err).

Back-to-back strobes:
- One beat per cycle is supported; no wait states outside WAIT.

err:
- Cleared only by init or reset.

Test Plan:
- Reset, then 16 loads of 0x0001..0x0010 (DW=16, MSG_W=256, BSWAP=0) → ack each cycle after; start pulses once, 1 cycle after the 16th load; msg = 0x0001_0002_..._0010; blk_cnt=1.
- Same stimulus with BSWAP=1, LANE_W=64 → msg lane 3 (MSBs) = 0x0400_0300_0200_0100; start timing identical.
- Core model: busy 1 for 20 cycles after start, digest=0x00..1F (byte i = i) → 16 fetches return 0x0001, 0x0203, ..., 0x1E1F; a 17th fetch returns 0x0001 (wrap).
- load during WAIT, plus fetch in IDLE after init → err=1, no ack, msg unchanged; the next init clears err to 0.
- load and fetch asserted together in DONE → load accepted, fetch dropped, dig_valid=0, err stays 0.
- rst_n low for 1 cycle after load beat 7 → all outputs 0 immediately; the next 16 loads produce a correct block and blk_cnt=1.

Source files
------------

// File: rtl/hash_bus_if_if.sv
// rtl/hash_bus_if_if.sv - host and core signal bundle for the hash bus front end
interface hash_bus_if_if #(
   parameter int DW    = 16,
   parameter int MSG_W = 256,
   parameter int DIG_W = 256,
   parameter int CNT_W = 32
);
   logic             init;
   logic             load;
   logic             fetch;
   logic [DW-1:0]    idata;
   logic [DW-1:0]    odata;
   logic             ack;
   logic             err;
   logic             core_init;
   logic             start;
   logic             busy;
   logic [MSG_W-1:0] msg;
   logic [DIG_W-1:0] digest;
   logic [CNT_W-1:0] blk_cnt;

   modport slave (
      input  init, load, fetch, idata, busy, digest,
      output odata, ack, err, core_init, start, msg, blk_cnt
   );

   modport master (
      output init, load, fetch, idata, busy, digest,
      input  odata, ack, err, core_init, start, msg, blk_cnt
   );
endinterface

// File: rtl/hash_bus_if.sv
// rtl/hash_bus_if.sv - narrow-bus block loader and digest reader for the hash cores
module hash_bus_if #(
   parameter int DW     = 16,
   parameter int MSG_W  = 256,
   parameter int DIG_W  = 256,
   parameter int LANE_W = 64,
   parameter int BSWAP  = 1,
   parameter int CNT_W  = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   hash_bus_if_if.slave  bus
);
   localparam int NM  = MSG_W / DW;
   localparam int ND  = DIG_W / DW;
   localparam int LCW = (NM > 1) ? $clog2(NM) : 1;
   localparam int FCW = (ND > 1) ? $clog2(ND) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

   state_t           state;
   logic [MSG_W-1:0] buf_q;
   logic [DIG_W-1:0] dig_q;
   logic [LCW-1:0]   lcnt;
   logic [FCW-1:0]   fcnt;
   logic             dig_valid;
   logic             busy_q;
   logic [DW-1:0]    odata_q;
   logic             ack_q;
   logic             err_q;
   logic             core_init_q;
   logic             start_q;
   logic [CNT_W-1:0] blk_cnt_q;

   logic [LCW-1:0]   widx;
   logic             last_beat;
   int               wbase;
   int               fbase;

   // A load outside LOAD always starts a fresh block at beat 0.
   always_comb begin
      widx      = (state == LOAD) ? lcnt : '0;
      last_beat = (widx == LCW'(NM - 1));
      wbase     = int'(widx) * DW;
      fbase     = int'(fcnt) * DW;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         buf_q       <= '0;
         dig_q       <= '0;
         lcnt        <= '0;
         fcnt        <= '0;
         dig_valid   <= 1'b0;
         busy_q      <= 1'b0;
         odata_q     <= '0;
         ack_q       <= 1'b0;
         err_q       <= 1'b0;
         core_init_q <= 1'b0;
         start_q     <= 1'b0;
         blk_cnt_q   <= '0;
      end else begin
         core_init_q <= bus.init;
         busy_q      <= bus.busy;
         ack_q       <= 1'b0;
         start_q     <= 1'b0;
         if (bus.init) begin
            state     <= IDLE;
            buf_q     <= '0;
            lcnt      <= '0;
            fcnt      <= '0;
            dig_valid <= 1'b0;
            err_q     <= 1'b0;
            blk_cnt_q <= '0;
         end else if (state == WAIT) begin
            if (bus.load || bus.fetch)
               err_q <= 1'b1;
            if (busy_q && !bus.busy) begin
               dig_q     <= bus.digest;
               dig_valid <= 1'b1;
               state     <= DONE;
            end
         end else if (bus.load) begin
            // Load wins over a simultaneous fetch; the fetch is dropped silently.
            buf_q[MSG_W-1-wbase -: DW] <= bus.idata;
            ack_q <= 1'b1;
            if (state != LOAD) begin
               dig_valid <= 1'b0;
               fcnt      <= '0;
            end
            if (last_beat) begin
               start_q   <= 1'b1;
               blk_cnt_q <= blk_cnt_q + 1'b1;
               lcnt      <= '0;
               state     <= WAIT;
            end else begin
               lcnt  <= widx + 1'b1;
               state <= LOAD;
            end
         end else if (bus.fetch) begin
            if (dig_valid) begin
               odata_q <= dig_q[DIG_W-1-fbase -: DW];
               ack_q   <= 1'b1;
               fcnt    <= (fcnt == FCW'(ND - 1)) ? '0 : fcnt + 1'b1;
            end else begin
               err_q <= 1'b1;
            end
         end
      end
   end

   assign bus.odata     = odata_q;
   assign bus.ack       = ack_q;
   assign bus.err       = err_q;
   assign bus.core_init = core_init_q;
   assign bus.start     = start_q;
   assign bus.blk_cnt   = blk_cnt_q;

   // Byte reversal inside each lane turns the big-endian beat stream into little-endian words.
   generate
      if (BSWAP != 0) begin : g_swap
         for (genvar l = 0; l < MSG_W / LANE_W; l++) begin : g_lane
            for (genvar b = 0; b < LANE_W / 8; b++) begin : g_byte
               assign bus.msg[l*LANE_W + b*8 +: 8] = buf_q[l*LANE_W + (LANE_W/8-1-b)*8 +: 8];
            end
         end
      end else begin : g_pass
         assign bus.msg = buf_q;
      end
   endgenerate
endmodule

// File: tb/tb_hash_bus_if.sv
// tb/tb_hash_bus_if.sv - directed checks of hash_bus_if with and without lane byte reversal
module tb_hash_bus_if;
   localparam int DW    = 16;
   localparam int MSG_W = 256;
   localparam int DIG_W = 256;
   localparam int CNT_W = 32;

   localparam logic [MSG_W-1:0] MSG_A = 256'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000a_000b_000c_000d_000e_000f_0010;
   localparam logic [MSG_W-1:0] MSG_B = 256'h0400_0300_0200_0100_0800_0700_0600_0500_0c00_0b00_0a00_0900_1000_0f00_0e00_0d00;
   localparam logic [MSG_W-1:0] MSG_C = 256'h0100_0101_0102_0103_0104_0105_0106_0107_0108_0109_010a_010b_010c_010d_010e_010f;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             init = 1'b0;
   logic             load = 1'b0;
   logic             fetch = 1'b0;
   logic [DW-1:0]    idata = '0;
   logic [DIG_W-1:0] digest = '0;
   logic             busy;
   int               bcnt;
   int               n_cmp = 0;
   int               n_mis = 0;

   always #5 clk = ~clk;

   hash_bus_if_if #(.DW(DW), .MSG_W(MSG_W), .DIG_W(DIG_W), .CNT_W(CNT_W)) i0 ();
   hash_bus_if_if #(.DW(DW), .MSG_W(MSG_W), .DIG_W(DIG_W), .CNT_W(CNT_W)) i1 ();

   assign i0.init = init;   assign i1.init = init;
   assign i0.load = load;   assign i1.load = load;
   assign i0.fetch = fetch; assign i1.fetch = fetch;
   assign i0.idata = idata; assign i1.idata = idata;
   assign i0.busy = busy;   assign i1.busy = busy;
   assign i0.digest = digest; assign i1.digest = digest;

   hash_bus_if #(.DW(DW), .MSG_W(MSG_W), .DIG_W(DIG_W), .LANE_W(64), .BSWAP(0), .CNT_W(CNT_W))
      u0 (.clk(clk), .rst_n(rst_n), .bus(i0.slave));
   hash_bus_if #(.DW(DW), .MSG_W(MSG_W), .DIG_W(DIG_W), .LANE_W(64), .BSWAP(1), .CNT_W(CNT_W))
      u1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));

   // Core model: busy for 20 cycles starting the cycle after start.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)          bcnt <= 0;
      else if (i0.start)   bcnt <= 20;
      else if (bcnt != 0)  bcnt <= bcnt - 1;
   end
   assign busy = (bcnt != 0);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_beats(input int n, input logic [DW-1:0] first, input bit chk);
      for (int k = 0; k < n; k++) begin
         load  = 1'b1;
         idata = first + DW'(k);
         tick();
         if (chk) begin
            n_cmp++; if (i0.ack !== 1'b1) begin n_mis++; $display("FAIL load_ack beat %0d: got %b want 1", k, i0.ack); end
            n_cmp++; if (i0.start !== (k == 15)) begin n_mis++; $display("FAIL start0 beat %0d: got %b want %b", k, i0.start, (k == 15)); end
            n_cmp++; if (i1.start !== (k == 15)) begin n_mis++; $display("FAIL start1 beat %0d: got %b want %b", k, i1.start, (k == 15)); end
         end
      end
      load = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      n_cmp++; if ({i0.odata, i0.ack, i0.err, i0.core_init, i0.start, i0.blk_cnt} !== '0) begin n_mis++; $display("FAIL reset_ctl0: got %h want 0", {i0.odata, i0.ack, i0.err, i0.core_init, i0.start, i0.blk_cnt}); end
      n_cmp++; if ({i1.odata, i1.ack, i1.err, i1.core_init, i1.start, i1.blk_cnt} !== '0) begin n_mis++; $display("FAIL reset_ctl1: got %h want 0", {i1.odata, i1.ack, i1.err, i1.core_init, i1.start, i1.blk_cnt}); end
      n_cmp++; if (i0.msg !== '0) begin n_mis++; $display("FAIL reset_msg0: got %h want 0", i0.msg); end
      n_cmp++; if (i1.msg !== '0) begin n_mis++; $display("FAIL reset_msg1: got %h want 0", i1.msg); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_load_block();
      load_beats(16, 16'h0001, 1'b1);
      tick();
      n_cmp++; if (i0.start !== 1'b0) begin n_mis++; $display("FAIL start_pulse_end: got %b want 0", i0.start); end
      n_cmp++; if (i0.ack !== 1'b0) begin n_mis++; $display("FAIL ack_idle: got %b want 0", i0.ack); end
      n_cmp++; if (i0.msg !== MSG_A) begin n_mis++; $display("FAIL msg_plain: got %h want %h", i0.msg, MSG_A); end
      n_cmp++; if (i1.msg !== MSG_B) begin n_mis++; $display("FAIL msg_bswap: got %h want %h", i1.msg, MSG_B); end
      n_cmp++; if (i0.blk_cnt !== 32'd1) begin n_mis++; $display("FAIL blk_cnt0: got %0d want 1", i0.blk_cnt); end
      n_cmp++; if (i1.blk_cnt !== 32'd1) begin n_mis++; $display("FAIL blk_cnt1: got %0d want 1", i1.blk_cnt); end
   endtask

   task automatic test_fetch_digest();
      int t;
      logic [DW-1:0] e;
      t = 0;
      while (!busy && t < 50) begin tick(); t++; end
      while (busy && t < 100) begin tick(); t++; end
      n_cmp++; if (t >= 100) begin n_mis++; $display("FAIL busy_wait: got timeout after %0d cycles want busy fall", t); end
      tick();
      for (int j = 0; j < 17; j++) begin
         fetch = 1'b1;
         tick();
         e = (j < 16) ? {8'(2 * j), 8'(2 * j + 1)} : 16'h0001;
         n_cmp++; if (i0.ack !== 1'b1) begin n_mis++; $display("FAIL fetch_ack %0d: got %b want 1", j, i0.ack); end
         n_cmp++; if (i0.odata !== e) begin n_mis++; $display("FAIL fetch_data %0d: got %h want %h", j, i0.odata, e); end
      end
      fetch = 1'b0;
      n_cmp++; if (i1.odata !== 16'h0001) begin n_mis++; $display("FAIL fetch_data1: got %h want 0001", i1.odata); end
      tick();
      n_cmp++; if (i0.ack !== 1'b0) begin n_mis++; $display("FAIL fetch_ack_end: got %b want 0", i0.ack); end
      n_cmp++; if (i0.err !== 1'b0) begin n_mis++; $display("FAIL fetch_err: got %b want 0", i0.err); end
   endtask

   task automatic test_load_fetch_together();
      load  = 1'b1;
      fetch = 1'b1;
      idata = 16'haaaa;
      tick();
      load  = 1'b0;
      fetch = 1'b0;
      n_cmp++; if (i0.ack !== 1'b1) begin n_mis++; $display("FAIL both_ack: got %b want 1", i0.ack); end
      n_cmp++; if (i0.err !== 1'b0) begin n_mis++; $display("FAIL both_err: got %b want 0", i0.err); end
      n_cmp++; if (i0.odata !== 16'h0001) begin n_mis++; $display("FAIL both_odata: got %h want 0001", i0.odata); end
      fetch = 1'b1;
      tick();
      fetch = 1'b0;
      n_cmp++; if (i0.err !== 1'b1) begin n_mis++; $display("FAIL fetch_in_load_err: got %b want 1", i0.err); end
      n_cmp++; if (i0.ack !== 1'b0) begin n_mis++; $display("FAIL fetch_in_load_ack: got %b want 0", i0.ack); end
      init = 1'b1;
      tick();
      init = 1'b0;
      n_cmp++; if (i0.core_init !== 1'b1) begin n_mis++; $display("FAIL core_init_hi: got %b want 1", i0.core_init); end
      n_cmp++; if (i0.err !== 1'b0) begin n_mis++; $display("FAIL init_err: got %b want 0", i0.err); end
      n_cmp++; if (i0.blk_cnt !== 32'd0) begin n_mis++; $display("FAIL init_blk_cnt: got %0d want 0", i0.blk_cnt); end
      n_cmp++; if (i0.msg !== '0) begin n_mis++; $display("FAIL init_msg: got %h want 0", i0.msg); end
      tick();
      n_cmp++; if (i0.core_init !== 1'b0) begin n_mis++; $display("FAIL core_init_lo: got %b want 0", i0.core_init); end
   endtask

   task automatic test_err_wait();
      load_beats(16, 16'h0100, 1'b0);
      load  = 1'b1;
      idata = 16'hffff;
      tick();
      load = 1'b0;
      n_cmp++; if (i0.ack !== 1'b0) begin n_mis++; $display("FAIL wait_load_ack: got %b want 0", i0.ack); end
      n_cmp++; if (i0.err !== 1'b1) begin n_mis++; $display("FAIL wait_load_err: got %b want 1", i0.err); end
      n_cmp++; if (i0.msg !== MSG_C) begin n_mis++; $display("FAIL wait_msg: got %h want %h", i0.msg, MSG_C); end
      n_cmp++; if (i0.blk_cnt !== 32'd1) begin n_mis++; $display("FAIL wait_blk_cnt: got %0d want 1", i0.blk_cnt); end
      init = 1'b1;
      tick();
      init = 1'b0;
      n_cmp++; if (i0.err !== 1'b0) begin n_mis++; $display("FAIL wait_init_err: got %b want 0", i0.err); end
      fetch = 1'b1;
      tick();
      fetch = 1'b0;
      n_cmp++; if (i0.err !== 1'b1) begin n_mis++; $display("FAIL idle_fetch_err: got %b want 1", i0.err); end
      n_cmp++; if (i0.ack !== 1'b0) begin n_mis++; $display("FAIL idle_fetch_ack: got %b want 0", i0.ack); end
      n_cmp++; if (i0.odata !== 16'h0001) begin n_mis++; $display("FAIL idle_fetch_odata: got %h want 0001", i0.odata); end
      init = 1'b1;
      tick();
      init = 1'b0;
      n_cmp++; if (i0.err !== 1'b0) begin n_mis++; $display("FAIL idle_init_err: got %b want 0", i0.err); end
   endtask

   task automatic test_reset_mid();
      load_beats(8, 16'h0001, 1'b0);
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({i0.odata, i0.ack, i0.err, i0.core_init, i0.start, i0.blk_cnt} !== '0) begin n_mis++; $display("FAIL mid_reset_ctl: got %h want 0", {i0.odata, i0.ack, i0.err, i0.core_init, i0.start, i0.blk_cnt}); end
      n_cmp++; if (i0.msg !== '0) begin n_mis++; $display("FAIL mid_reset_msg0: got %h want 0", i0.msg); end
      n_cmp++; if (i1.msg !== '0) begin n_mis++; $display("FAIL mid_reset_msg1: got %h want 0", i1.msg); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      load_beats(16, 16'h0001, 1'b1);
      tick();
      n_cmp++; if (i0.msg !== MSG_A) begin n_mis++; $display("FAIL post_reset_msg0: got %h want %h", i0.msg, MSG_A); end
      n_cmp++; if (i1.msg !== MSG_B) begin n_mis++; $display("FAIL post_reset_msg1: got %h want %h", i1.msg, MSG_B); end
      n_cmp++; if (i0.blk_cnt !== 32'd1) begin n_mis++; $display("FAIL post_reset_blk_cnt: got %0d want 1", i0.blk_cnt); end
   endtask

   initial begin
      for (int i = 0; i < DIG_W / 8; i++)
         digest[DIG_W-1-8*i -: 8] = 8'(i);
      test_reset();
      test_load_block();
      test_fetch_digest();
      test_load_fetch_together();
      test_err_wait();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
